// File: rtl/gray_step_encoder_pkg.sv
// gray_step_encoder_pkg: shared types, segment patterns and helpers for the Gray step encoder.
package gray_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} deb_state_t;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      default: return SEG_9;
    endcase
  endfunction
endpackage

// File: rtl/gray_step_encoder_if.sv
// gray_step_encoder_if: button inputs and Gray/LED/display outputs of the encoder.
interface gray_step_encoder_if #(parameter int WIDTH = 4);
  logic btn_up;
  logic btn_down;
  logic [WIDTH-1:0] gray_code;
  logic gray_valid;
  logic [5:0] leds;
  logic [1:0] digit_sel;
  logic [6:0] display_code;
  modport master(output btn_up, btn_down, input gray_code, gray_valid, leds, digit_sel, display_code);
  modport slave(input btn_up, btn_down, output gray_code, gray_valid, leds, digit_sel, display_code);
endinterface

// File: rtl/gray_step_encoder_debouncer.sv
// button_debouncer: synchronises a raw button and emits one step pulse per debounced press.
module button_debouncer
  import gray_pkg::*;
#(
  parameter int DEB_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic level;
  logic done;
  logic [CW-1:0] cnt;
  deb_state_t state, nxt;
  assign level = sync[1];
  assign done = cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      state <= nxt;
      cnt <= (nxt != state) ? '0 : done ? cnt : cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    step = 1'b0;
    case (state)
      IDLE: nxt = level ? WAIT_PRESS : IDLE;
      WAIT_PRESS: begin
        nxt = !level ? IDLE : done ? PRESSED : WAIT_PRESS;
        step = level && done;
      end
      PRESSED: nxt = level ? PRESSED : WAIT_RELEASE;
      WAIT_RELEASE: nxt = level ? PRESSED : done ? IDLE : WAIT_RELEASE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/gray_step_encoder.sv
// gray_step_encoder: up/down button counter emitted as registered Gray code with LED and 2-digit display.
module gray_step_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH = gray_pkg::WIDTH,
  parameter int DEB_CYCLES = 270000,
  parameter int REFRESH_CYCLES = 27000
) (
  input logic clk,
  input logic rst,
  gray_step_encoder_if.slave bus
);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [1:0] rst_q;
  logic rst_i;
  logic up, dn;
  logic [WIDTH-1:0] count, nxt_count;
  logic [3:0] val, digit;
  logic [RW-1:0] rcnt;
  logic wrap;
  logic [1:0] nxt_sel;
  // Assert asynchronously, release only after two clean clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];
  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_up (.clk(clk), .rst(rst_i), .btn(bus.btn_up), .step(up));
  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_dn (.clk(clk), .rst(rst_i), .btn(bus.btn_down), .step(dn));
  assign nxt_count = (up && !dn) ? count + 1'b1 : (dn && !up) ? count - 1'b1 : count;
  assign val = 4'(nxt_count);
  assign wrap = rcnt == RW'(REFRESH_CYCLES - 1);
  assign nxt_sel = wrap ? {bus.digit_sel[0], bus.digit_sel[1]} : bus.digit_sel;
  // Segments follow the post-edge count so the shown digit never lags the Gray output.
  assign digit = nxt_sel[0] ? ((val >= 4'd10) ? val - 4'd10 : val) : {3'b000, val >= 4'd10};
  assign bus.leds = 6'(bus.gray_code);
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      bus.gray_code <= '0;
      bus.gray_valid <= 1'b0;
      rcnt <= '0;
      bus.digit_sel <= 2'b01;
      bus.display_code <= SEG_0;
    end else begin
      count <= nxt_count;
      bus.gray_code <= bin2gray(nxt_count);
      bus.gray_valid <= up ^ dn;
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      bus.digit_sel <= nxt_sel;
      bus.display_code <= seg7(digit);
    end
  end
endmodule

// File: tb/tb_gray_step_encoder.sv
// tb_gray_step_encoder: random button presses checked against a press-level counter model.
module tb_gray_step_encoder;
  localparam int DEB = 4;
  localparam int REF = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int exp_cnt = 0;
  logic [3:0] prev_gray = '0;
  logic [6:0] seg_tab [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
  always #5 clk = ~clk;
  gray_step_encoder_if #(.WIDTH(4)) bus ();
  gray_step_encoder #(.WIDTH(4), .DEB_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] gray_of(int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction
  always @(negedge clk) begin
    if (rst) prev_gray = '0;
    else begin
      if (bus.gray_valid) pulses++;
      if (bus.gray_valid || bus.gray_code != prev_gray)
        check("valid_tracks_change", 32'(bus.gray_valid), 32'(bus.gray_code != prev_gray));
      prev_gray = bus.gray_code;
    end
  end
  task automatic check_reset_outputs();
    check("rst_gray", 32'(bus.gray_code), 32'h0);
    check("rst_leds", 32'(bus.leds), 32'h0);
    check("rst_sel", 32'(bus.digit_sel), 32'h1);
    check("rst_disp", 32'(bus.display_code), 32'h3f);
    check("rst_valid", 32'(bus.gray_valid), 32'h0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    exp_cnt = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_sel(logic [1:0] s);
    int k = 0;
    while (bus.digit_sel !== s && k < 4 * REF) begin
      @(negedge clk);
      k++;
    end
    check("digit_sel_reach", 32'(bus.digit_sel), 32'(s));
  endtask
  task automatic check_display(int v);
    wait_sel(2'b01);
    check("units_seg", 32'(bus.display_code), 32'(seg_tab[v % 10]));
    wait_sel(2'b10);
    check("tens_seg", 32'(bus.display_code), 32'(seg_tab[v / 10]));
  endtask
  task automatic press(logic up, logic dn, int hold);
    int p0;
    bit step;
    p0 = pulses;
    step = hold >= 10 && up != dn;
    bus.btn_up = up;
    bus.btn_down = dn;
    repeat (hold) @(negedge clk);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    repeat (16) @(negedge clk);
    if (step) exp_cnt = up ? (exp_cnt + 1) % 16 : (exp_cnt + 15) % 16;
    check("pulse_count", 32'(pulses - p0), step ? 32'd1 : 32'd0);
    check("gray_code", 32'(bus.gray_code), 32'(gray_of(exp_cnt)));
    check("leds", 32'(bus.leds), 32'(gray_of(exp_cnt)));
  endtask
  initial begin
    int p0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    do_reset();
    p0 = pulses;
    repeat (3) press(1'b1, 1'b0, 12);
    check("three_up_gray", 32'(bus.gray_code), 32'b0010);
    check("three_up_pulses", 32'(pulses - p0), 32'd3);
    check_display(3);
    do_reset();
    press(1'b0, 1'b1, 12);
    check("down_wrap_gray", 32'(bus.gray_code), 32'b1000);
    check_display(15);
    press(1'b1, 1'b0, 2);
    do_reset();
    repeat (6) press(1'b1, 1'b0, 12);
    check("six_gray", 32'(bus.gray_code), 32'b0101);
    press(1'b1, 1'b1, 12);
    check("both_gray", 32'(bus.gray_code), 32'b0101);
    press(1'b1, 1'b0, 100);
    check_display(exp_cnt);
    repeat (30) begin
      case ($urandom_range(0, 3))
        0: press(1'b1, 1'b0, $urandom_range(10, 30));
        1: press(1'b0, 1'b1, $urandom_range(10, 30));
        2: begin
          if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, $urandom_range(1, 2));
          else press(1'b0, 1'b1, $urandom_range(1, 2));
        end
        default: press(1'b1, 1'b1, $urandom_range(10, 30));
      endcase
      check_display(exp_cnt);
    end
    if (exp_cnt == 0) press(1'b1, 1'b0, 12);
    bus.btn_up = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    p0 = pulses;
    bus.btn_up = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    repeat (20) @(negedge clk);
    check("post_rst_gray", 32'(bus.gray_code), 32'h0);
    check("post_rst_pulses", 32'(pulses - p0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
